// File: rtl/cpu_pkg.sv
// Shared widths, register indices and shifter opcodes for the operand fetch stage.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] REG_PC    = 4'd15;
    localparam logic [DATA_W-1:0] PC_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_op_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of the issue-side, write-back and shifter/ALU-side signals of operand_fetch.
// The master side is whoever drives the decoded instruction and write-back strobe.
interface operand_fetch_if;
    import cpu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [ADDR_W-1:0]   in_rn;
    logic [ADDR_W-1:0]   in_rm;
    logic                in_use_rn;
    logic                in_imm_sel;
    logic [DATA_W-1:0]   in_imm;
    shift_op_t           in_shift_op;
    logic [DATA_W-1:0]   in_pc;
    logic                in_wb_req;
    logic [ADDR_W-1:0]   in_wb_dst;

    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_val_a;
    logic [DATA_W-1:0]   shift_in;
    shift_op_t           shift_op;

    modport master (
        output in_valid, in_rn, in_rm, in_use_rn, in_imm_sel, in_imm,
               in_shift_op, in_pc, in_wb_req, in_wb_dst,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_val_a, shift_in, shift_op
    );

    modport slave (
        input  in_valid, in_rn, in_rm, in_use_rn, in_imm_sel, in_imm,
               in_shift_op, in_pc, in_wb_req, in_wb_dst,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_val_a, shift_in, shift_op
    );

endinterface

// File: rtl/operand_fetch_regfile.sv
// 16x32 architectural register storage: two async read ports, one sync write port,
// synchronous active-low clear. R15 gating is done by the caller.
module operand_fetch_regfile
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr_a,
    output logic [DATA_W-1:0]  o_rdata_a,
    input  logic [ADDR_W-1:0]  i_raddr_b,
    output logic [DATA_W-1:0]  o_rdata_b
);

    logic [DATA_W-1:0] r_mem [NREGS];

    // Clear on reset (which also swallows a same-cycle write), otherwise write one entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the shifter/ALU: reads Rn/Rm, resolves RAW hazards with a
// pending-write scoreboard plus write-back bypass, and registers the operands.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    operand_fetch_if.slave     bus
);

    logic [DATA_W-1:0] w_rf_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_pc_val;
    logic [DATA_W-1:0] w_rd_rn;
    logic [DATA_W-1:0] w_rd_rm;
    logic              w_wb_we;
    logic              w_hz;
    logic              w_ready;
    logic              w_accept;
    logic [NREGS-1:0]  w_pending_nxt;

    logic [NREGS-1:0]  r_pending;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_val_a;
    logic [DATA_W-1:0] r_shift_in;
    shift_op_t         r_shift_op;

    // R15 is architecturally the PC and never lives in storage.
    assign w_wb_we = bus.wb_en && (bus.wb_addr != REG_PC);

    operand_fetch_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_wb_we),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (bus.in_rn),
        .o_rdata_a (w_rf_a),
        .i_raddr_b (bus.in_rm),
        .o_rdata_b (w_rf_b)
    );

    assign w_pc_val = bus.in_pc + PC_OFFSET;

    // Operand read: PC first, then same-cycle write-back bypass, then storage.
    always_comb begin
        w_rd_rn = w_rf_a;
        if (bus.in_rn == REG_PC) begin
            w_rd_rn = w_pc_val;
        end else if (bus.wb_en && (bus.wb_addr == bus.in_rn)) begin
            w_rd_rn = bus.wb_data;
        end

        w_rd_rm = w_rf_b;
        if (bus.in_rm == REG_PC) begin
            w_rd_rm = w_pc_val;
        end else if (bus.wb_en && (bus.wb_addr == bus.in_rm)) begin
            w_rd_rm = bus.wb_data;
        end
    end

    // A pending source stalls unless its write-back arrives this very cycle.
    assign w_hz = (bus.in_use_rn && r_pending[bus.in_rn]
                   && !(bus.wb_en && (bus.wb_addr == bus.in_rn)))
                | (!bus.in_imm_sel && r_pending[bus.in_rm]
                   && !(bus.wb_en && (bus.wb_addr == bus.in_rm)));

    assign w_ready  = rst_n && !w_hz && (!r_out_valid || bus.out_ready);
    assign w_accept = bus.in_valid && w_ready;

    // Scoreboard update: clear on write-back, then set on accept so a set wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wb_we) begin
            w_pending_nxt[bus.wb_addr] = 1'b0;
        end
        if (w_accept && bus.in_wb_req && (bus.in_wb_dst != REG_PC)) begin
            w_pending_nxt[bus.in_wb_dst] = 1'b1;
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Output register: load on accept, drop valid on drain, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_val_a     <= '0;
            r_shift_in  <= '0;
            r_shift_op  <= SH_PASS;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_val_a     <= bus.in_use_rn ? w_rd_rn : '0;
            r_shift_in  <= bus.in_imm_sel ? bus.in_imm : w_rd_rm;
            r_shift_op  <= bus.in_shift_op;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_val_a = r_val_a;
    assign bus.shift_in  = r_shift_in;
    assign bus.shift_op  = r_shift_op;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, read/bypass, RAW stall, back-pressure,
// PC/immediate selection, scoreboard set-vs-clear and reset while busy.
module tb_operand_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_rn       = '0;
        bus.in_rm       = '0;
        bus.in_use_rn   = 1'b0;
        bus.in_imm_sel  = 1'b0;
        bus.in_imm      = '0;
        bus.in_shift_op = SH_PASS;
        bus.in_pc       = '0;
        bus.in_wb_req   = 1'b0;
        bus.in_wb_dst   = '0;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.out_ready   = 1'b1;
    endtask

    task automatic issue_imm(input logic [31:0] imm);
        bus.in_valid   = 1'b1;
        bus.in_use_rn  = 1'b0;
        bus.in_imm_sel = 1'b1;
        bus.in_imm     = imm;
        bus.in_wb_req  = 1'b0;
    endtask

    initial begin
        logic [31:0] imms [4];
        n_total = 0;
        n_bad   = 0;
        imms[0] = 32'h11; imms[1] = 32'h22; imms[2] = 32'h33; imms[3] = 32'h44;
        idle_inputs();
        rst_n = 1'b0;

        // 1. reset
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_val_a", bus.out_val_a, 32'd0);
        chk("rst_shift_in", bus.shift_in, 32'd0);
        chk("rst_shift_op", 32'(bus.shift_op), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 2. write R3, read it on both ports
        bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'h0000_00F0;
        step();
        bus.wb_en = 1'b0;
        bus.in_valid = 1'b1; bus.in_rn = 4'd3; bus.in_rm = 4'd3;
        bus.in_use_rn = 1'b1; bus.in_imm_sel = 1'b0; bus.in_shift_op = SH_LSL1;
        #1;
        chk("r3_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("r3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("r3_val_a", bus.out_val_a, 32'h0000_00F0);
        chk("r3_shift_in", bus.shift_in, 32'h0000_00F0);
        chk("r3_shift_op", 32'(bus.shift_op), 32'd1);
        step();
        chk("drain_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_hold_a", bus.out_val_a, 32'h0000_00F0);

        // 3. RAW stall on R5 released by write-back bypass
        bus.in_shift_op = SH_PASS;
        issue_imm(32'h0);
        bus.in_wb_req = 1'b1; bus.in_wb_dst = 4'd5;
        step();
        chk("wbreq_val_a", bus.out_val_a, 32'd0);
        chk("wbreq_shift_in", bus.shift_in, 32'd0);
        bus.in_wb_req = 1'b0; bus.in_imm_sel = 1'b0;
        bus.in_use_rn = 1'b1; bus.in_rn = 4'd3; bus.in_rm = 4'd5;
        #1;
        chk("raw_stall0", 32'(bus.in_ready), 32'd0);
        step();
        chk("raw_stall1", 32'(bus.in_ready), 32'd0);
        chk("raw_no_issue", 32'(bus.out_valid), 32'd0);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'h1234;
        #1;
        chk("raw_bypass_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.wb_en = 1'b0; bus.in_valid = 1'b0;
        chk("raw_shift_in", bus.shift_in, 32'h1234);
        chk("raw_val_a", bus.out_val_a, 32'h0000_00F0);
        step();

        // 4. back-pressure, then back-to-back drain
        issue_imm(imms[0]);
        step();
        chk("bp_first", bus.shift_in, imms[0]);
        bus.out_ready = 1'b0;
        bus.in_imm = imms[1];
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_data", bus.shift_in, imms[0]);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            bus.in_imm = imms[i];
            #1;
            chk("b2b_ready", 32'(bus.in_ready), 32'd1);
            step();
            chk("b2b_data", bus.shift_in, imms[i]);
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b_drain", 32'(bus.out_valid), 32'd0);

        // 5. R15 reads PC+8; immediate bypasses a pending Rm
        bus.in_valid = 1'b1; bus.in_imm_sel = 1'b0; bus.in_use_rn = 1'b1;
        bus.in_rn = 4'd15; bus.in_rm = 4'd15; bus.in_pc = 32'h100;
        bus.in_wb_req = 1'b1; bus.in_wb_dst = 4'd9;
        step();
        chk("pc_shift_in", bus.shift_in, 32'h108);
        chk("pc_val_a", bus.out_val_a, 32'h108);
        bus.in_wb_req = 1'b0; bus.in_use_rn = 1'b0; bus.in_rm = 4'd9;
        #1;
        chk("rm9_stall", 32'(bus.in_ready), 32'd0);
        bus.in_imm_sel = 1'b1; bus.in_imm = 32'hFFFF_8000;
        #1;
        chk("imm_no_stall", 32'(bus.in_ready), 32'd1);
        step();
        chk("imm_shift_in", bus.shift_in, 32'hFFFF_8000);

        // 6. set wins over same-cycle clear, then reset while busy
        issue_imm(32'h5);
        bus.in_wb_req = 1'b1; bus.in_wb_dst = 4'd7;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 32'h77;
        step();
        bus.wb_en = 1'b0; bus.in_wb_req = 1'b0; bus.in_valid = 1'b0;
        bus.in_imm_sel = 1'b0; bus.in_rm = 4'd7;
        #1;
        chk("set_wins_stall", 32'(bus.in_ready), 32'd0);
        chk("busy_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 32'hDEAD;
        step();
        bus.wb_en = 1'b0;
        chk("rst2_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_shift_in", 32'(bus.shift_in), 32'd0);
        rst_n = 1'b1; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_use_rn = 1'b1; bus.in_rn = 4'd4;
        #1;
        chk("rst2_pending_clr", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("rst2_wb_ignored", bus.out_val_a, 32'd0);
        chk("rst2_rf_cleared", bus.shift_in, 32'd0);
        chk("rst2_reissue_valid", 32'(bus.out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
